// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: data/HI-LO stall detection, operand forwarding selects,
// multi-cycle mult/div busy tracking and a saturating stalled-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  WBA_E,
    input  logic [1:0]  tnew_E,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  WBA_M,
    input  logic [1:0]  tnew_M,
    input  logic [4:0]  WBA_W,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        fwd_rt_M,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);

    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        data_stall, md_stall, stall;

    // A D-stage operand stalls when its producer in E or M is still further out than its use.
    function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] wba_e, input logic [1:0] tnew_e,
                                       input logic [4:0] wba_m, input logic [1:0] tnew_m);
        logic hit;
        hit = 1'b0;
        if (src != 5'd0 && tuse != 2'd3) begin
            if (src == wba_e && tuse < tnew_e) hit = 1'b1;
            if (src == wba_m && tuse < tnew_m) hit = 1'b1;
        end
        return hit;
    endfunction

    // M is the younger producer, so it wins over W when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wba_m,
                                           input logic [1:0] tnew_m, input logic [4:0] wba_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (src == wba_m && tnew_m == 2'd0) sel = 2'd2;
            else if (src == wba_w)              sel = 2'd1;
        end
        return sel;
    endfunction

    always_comb begin
        data_stall = src_stall(rs_D, tuse_rs_D, WBA_E, tnew_E, WBA_M, tnew_M) |
                     src_stall(rt_D, tuse_rt_D, WBA_E, tnew_E, WBA_M, tnew_M);
        md_stall   = md_D & (md_busy | md_start_E);
        stall      = data_stall | md_stall;
        stall_F    = stall;
        stall_D    = stall;
        flush_E    = stall;
    end

    always_comb begin
        fwd_rs_D = fwd_sel(rs_D, WBA_M, tnew_M, WBA_W);
        fwd_rt_D = fwd_sel(rt_D, WBA_M, tnew_M, WBA_W);
        fwd_rs_E = fwd_sel(rs_E, WBA_M, tnew_M, WBA_W);
        fwd_rt_E = fwd_sel(rt_E, WBA_M, tnew_M, WBA_W);
        fwd_rt_M = (rt_M != 5'd0) && (rt_M == WBA_W);
    end

    // A start while the unit is already counting is dropped, not restarted.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_E && md_cnt_q == 4'd0) begin
            md_cnt_d = md_div_E ? DivLoad : MultLoad;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = (md_cnt_q != 4'd0);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven combinational vectors through a
// scoreboard queue, plus sequences for the HI/LO busy window, async reset and stats.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E, WBA_E, rt_M, WBA_M, WBA_W;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_D, md_start_E, md_div_E;
    logic        stall_F, stall_D, flush_E, fwd_rt_M, md_busy;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_D(md_D),
        .rs_E(rs_E), .rt_E(rt_E), .WBA_E(WBA_E), .tnew_E(tnew_E),
        .md_start_E(md_start_E), .md_div_E(md_div_E),
        .rt_M(rt_M), .WBA_M(WBA_M), .tnew_M(tnew_M), .WBA_W(WBA_W),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .fwd_rt_M(fwd_rt_M), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs_D, rt_D;
        logic [1:0] tuse_rs_D, tuse_rt_D;
        logic [4:0] rs_E, rt_E, WBA_E;
        logic [1:0] tnew_E;
        logic [4:0] rt_M, WBA_M;
        logic [1:0] tnew_M;
        logic [4:0] WBA_W;
        logic       e_stall;
        logic [1:0] e_rsd, e_rtd, e_rse, e_rte;
        logic       e_rtm;
    } vec_t;

    vec_t       vt[$];
    vec_t       exp_q[$];
    logic [1:0] md_q[$];   // {busy, stall}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_D = 0; rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0; md_D = 0;
        rs_E = 0; rt_E = 0; WBA_E = 0; tnew_E = 0; md_start_E = 0; md_div_E = 0;
        rt_M = 0; WBA_M = 0; tnew_M = 0; WBA_W = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic on);
        rs_D = on ? 5'd5 : 5'd0; WBA_E = on ? 5'd5 : 5'd0;
        tnew_E = on ? 2'd2 : 2'd0; tuse_rs_D = on ? 2'd1 : 2'd0;
    endtask

    initial begin
        vec_t v, e;
        logic [1:0] m;
        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;

        // Vector table
        v = '0; v.WBA_E = 5; v.tnew_E = 2; v.rs_D = 5; v.tuse_rs_D = 1; v.e_stall = 1; vt.push_back(v);
        v = '0; v.WBA_M = 5; v.tnew_M = 1; v.rs_D = 5; v.tuse_rs_D = 1; vt.push_back(v);
        v = '0; v.rs_E = 8; v.WBA_M = 8; v.WBA_W = 8; v.e_rse = 2; vt.push_back(v);
        v = '0; v.rs_E = 8; v.WBA_M = 8; v.tnew_M = 1; v.WBA_W = 8; v.e_rse = 1; vt.push_back(v);
        v = '0; v.WBA_M = 8; v.WBA_W = 8; vt.push_back(v);
        v = '0; v.rt_D = 7; v.WBA_E = 7; v.tnew_E = 2; v.tuse_rt_D = 3; vt.push_back(v);
        v = '0; v.rt_D = 7; v.WBA_E = 7; v.tnew_E = 2; v.tuse_rt_D = 1; v.e_stall = 1; vt.push_back(v);
        v = '0; v.rt_D = 7; v.WBA_M = 7; v.tnew_M = 1; v.e_stall = 1; vt.push_back(v);
        v = '0; v.rt_D = 7; v.WBA_E = 7; v.tnew_E = 2; v.tuse_rt_D = 2; vt.push_back(v);
        v = '0; v.tnew_E = 2; v.tnew_M = 1; vt.push_back(v);
        v = '0; v.rs_D = 3; v.rt_D = 4; v.WBA_M = 3; v.WBA_W = 4; v.e_rsd = 2; v.e_rtd = 1;
        vt.push_back(v);
        v = '0; v.rt_M = 9; v.rt_E = 9; v.WBA_W = 9; v.e_rte = 1; v.e_rtm = 1; vt.push_back(v);
        v = '0; v.rt_E = 6; v.WBA_M = 6; v.tnew_M = 1; v.WBA_W = 6; v.e_rte = 1; vt.push_back(v);

        do_reset();
        @(negedge clk);
        chk("reset_busy", 32'(md_busy), 0);
        chk("reset_cnt", stall_cnt, 0);
        chk("reset_stall", 32'(stall_F), 0);

        foreach (vt[i]) begin
            @(posedge clk); #1;
            rs_D = vt[i].rs_D; rt_D = vt[i].rt_D;
            tuse_rs_D = vt[i].tuse_rs_D; tuse_rt_D = vt[i].tuse_rt_D;
            rs_E = vt[i].rs_E; rt_E = vt[i].rt_E; WBA_E = vt[i].WBA_E; tnew_E = vt[i].tnew_E;
            rt_M = vt[i].rt_M; WBA_M = vt[i].WBA_M; tnew_M = vt[i].tnew_M; WBA_W = vt[i].WBA_W;
            exp_q.push_back(vt[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_stall_F", i), 32'(stall_F), 32'(e.e_stall));
            chk($sformatf("v%0d_stall_D", i), 32'(stall_D), 32'(e.e_stall));
            chk($sformatf("v%0d_flush_E", i), 32'(flush_E), 32'(e.e_stall));
            chk($sformatf("v%0d_fwd_rs_D", i), 32'(fwd_rs_D), 32'(e.e_rsd));
            chk($sformatf("v%0d_fwd_rt_D", i), 32'(fwd_rt_D), 32'(e.e_rtd));
            chk($sformatf("v%0d_fwd_rs_E", i), 32'(fwd_rs_E), 32'(e.e_rse));
            chk($sformatf("v%0d_fwd_rt_E", i), 32'(fwd_rt_E), 32'(e.e_rte));
            chk($sformatf("v%0d_fwd_rt_M", i), 32'(fwd_rt_M), 32'(e.e_rtm));
        end

        // Divide: busy for cycles 1..10, md_D stalls through cycle 10
        do_reset();
        md_D = 1; md_start_E = 1; md_div_E = 1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) md_start_E = 0;
            md_q.push_back({(c >= 1 && c <= 10), (c <= 10)});
            @(negedge clk);
            m = md_q.pop_front();
            chk($sformatf("div_c%0d_busy", c), 32'(md_busy), 32'(m[1]));
            chk($sformatf("div_c%0d_stall", c), 32'(stall_D), 32'(m[0]));
            @(posedge clk); #1;
        end

        // Multiply with a second start at cycle 3 that must be ignored
        do_reset();
        md_start_E = 1; md_div_E = 0;
        for (int c = 0; c <= 7; c++) begin
            md_start_E = (c == 0 || c == 3);
            md_q.push_back({(c >= 1 && c <= 5), 1'b0});
            @(negedge clk);
            m = md_q.pop_front();
            chk($sformatf("mul_c%0d_busy", c), 32'(md_busy), 32'(m[1]));
            chk($sformatf("mul_c%0d_stall", c), 32'(stall_F), 32'(m[0]));
            @(posedge clk); #1;
        end

        // Async reset in the middle of a divide
        do_reset();
        md_D = 1; md_start_E = 1; md_div_E = 1;
        @(posedge clk); #1 md_start_E = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_cnt", stall_cnt, 3);
        chk("abort_pre_busy", 32'(md_busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy_now", 32'(md_busy), 0);
        chk("abort_cnt_now", stall_cnt, 0);
        md_D = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_busy_after", 32'(md_busy), 0);
        end

        // Reset held: stall is still combinational but the counter stays put
        rst = 1'b1;
        set_load_use(1);
        @(negedge clk);
        chk("rst_stall_comb", 32'(stall_F), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt_frozen", stall_cnt, 0);
        set_load_use(0);
        @(posedge clk); #1 rst = 1'b0;

        // Seven stalled cycles
        set_load_use(1);
        repeat (7) @(posedge clk);
        #1 set_load_use(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stats_seven", stall_cnt, 7);

        // Saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        #1 chk("sat_loaded", stall_cnt, 32'hFFFF_FFFF);
        set_load_use(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        set_load_use(0);

        chk("sb_drained", 32'(exp_q.size() + md_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, mult/multu busy duration in cycles (1..15).
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, div/divu busy duration in cycles (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rs_D, rt_D  input  5 each  D-stage source register numbers.
REQ-006 SHALL have ports tuse_rs_D, tuse_rt_D  input  2 each  cycles until D-stage operand is consumed; 3 = operand unused.
REQ-007 SHALL have port md_D  input  1  D-stage instruction uses HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 SHALL have ports rs_E, rt_E, WBA_E  input  5 each  E-stage sources and write-back address.
REQ-009 SHALL have port tnew_E  input  2  cycles until E-stage result is available (0..2).
REQ-010 SHALL have ports md_start_E  input  1  E-stage mult/div issues this cycle; md_div_E  input  1  1 = div, 0 = mult.
REQ-011 SHALL have ports rt_M, WBA_M  input  5 each; tnew_M  input  2 (0..1).
REQ-012 SHALL have port WBA_W  input  5  W-stage write-back address (result always ready).
REQ-013 SHALL have outputs stall_F, stall_D, flush_E  1 each  PC hold, F/D register hold, D/E register clear.
REQ-014 SHALL have outputs fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E  2 each  0 = register file/pipe, 1 = from W, 2 = from M.
REQ-015 SHALL have output fwd_rt_M  1  1 = from W.
REQ-016 SHALL have outputs md_busy  1  HI/LO unit busy; stall_cnt  32  count of stalled cycles.

Function
REQ-017 Register number 0 SHALL never match for stall or forwarding.
REQ-018 Data stall SHALL assert when, for src in {rs_D, rt_D} with tuse != 3: (src==WBA_E and tuse < tnew_E) or (src==WBA_M and tuse < tnew_M).
REQ-019 MD stall SHALL assert when md_D and (md_busy or md_start_E).
REQ-020 stall = data stall OR MD stall; stall_F = stall_D = flush_E = stall, combinational, same cycle.
REQ-021 fwd_*_D SHALL be 2 if src==WBA_M and tnew_M==0, else 1 if src==WBA_W, else 0; M has priority over W.
REQ-022 fwd_*_E SHALL use the same rule on rs_E/rt_E.
REQ-023 fwd_rt_M SHALL be 1 iff rt_M==WBA_W and rt_M != 0.
REQ-024 Forward selects SHALL be computed regardless of stall.
REQ-025 MD counter (4 bits): on md_start_E with counter 0, load DIV_CYCLES if md_div_E else MULT_CYCLES; else decrement if nonzero.
REQ-026 md_busy SHALL equal (counter != 0), registered; first busy cycle is the cycle after md_start_E.
REQ-027 md_start_E while counter != 0 SHALL be ignored (no reload, no extension).
REQ-028 Busy duration SHALL be exactly MULT_CYCLES/DIV_CYCLES cycles of md_busy high.
REQ-029 stall_cnt SHALL increment by 1 on each rising edge where stall is high; SHALL saturate at 0xFFFFFFFF.

Reset
REQ-030 rst high SHALL immediately clear MD counter, md_busy and stall_cnt to 0, independent of clk.
REQ-031 During rst, stall SHALL depend only on combinational inputs; counters SHALL not advance.
REQ-032 Reset mid-multiply SHALL abort the busy period; md_busy = 0 after release until next md_start_E.

Verification
REQ-033 Load-use: WBA_E=5, tnew_E=2, rs_D=5, tuse_rs_D=1 -> stall_F=stall_D=flush_E=1; next cycle WBA_M=5, tnew_M=1, tuse_rs_D=1 -> stall=0.
REQ-034 Forward priority: rs_E=8, WBA_M=8, tnew_M=0, WBA_W=8 -> fwd_rs_E=2; tnew_M=1 -> fwd_rs_E=1; rs_E=0 -> 0.
REQ-035 Divide: md_start_E=1, md_div_E=1 at cycle 0 -> md_busy high cycles 1..10, low cycle 11; md_D=1 at cycle 0..10 -> stall=1, cycle 11 -> stall=0.
REQ-036 Re-issue: md_start_E pulsed at cycle 3 of a mult -> md_busy still drops after 5 busy cycles total.
REQ-037 Async reset: assert rst between edges during busy div -> md_busy=0 and stall_cnt=0 immediately, before next edge.
REQ-038 Stats: 7 stalled cycles from reset -> stall_cnt=7; force count 0xFFFFFFFF then stall -> remains 0xFFFFFFFF.
